async_fifo_wr_ctrl: RTL and testbench
=====================================

# async_fifo_wr_ctrl

Parametrised write-side controller for the dual-clock FIFO, living entirely in the W_CLK domain. It holds the binary and Gray write pointers and synchronises the read-side Gray pointer through a configurable flop chain. It also produces registered full, almost-full and fill-level outputs plus a sticky overflow flag. It drives the write port of the FIFO memory and feeds its Gray pointer to the read-side controller.

## Interface
- ADDR_WIDTH, 3: memory address bits; depth = 2^ADDR_WIDTH; must be ≥ 2.
- SYNC_STAGES, 2: flop stages on the incoming read pointer; must be ≥ 2.
- AFULL_LEVEL, 6: wr_afull asserts when the fill level is ≥ this value; range 1..2^ADDR_WIDTH.

Ports:
- W_CLK  in  1  write clock.
- W_RST  in  1  reset, asynchronous, active-low.
- wr_inc  in  1  write request for the current cycle.
- wr_clr_ovf  in  1  clears wr_ovf.
- gray_rd_ptr  in  ADDR_WIDTH+1  read pointer (Gray) from the R_CLK domain; unsynchronised.
- wr_en  out  1  memory write strobe, = wr_inc & ~wr_full (combinational).
- wr_addr  out  ADDR_WIDTH  memory write address, = binary pointer LSBs.
- gray_wr_ptr  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- wr_full  out  1  registered full flag.
- wr_afull  out  1  registered almost-full flag.
- wr_level  out  ADDR_WIDTH+1  registered fill level, 0..2^ADDR_WIDTH.
- wr_ovf  out  1  sticky overflow flag.

## Operation
- Binary pointer wb is ADDR_WIDTH+1 bits. On each edge: wb_next = wb + wr_en. Wrap modulo 2^(ADDR_WIDTH+1) is natural.
- gray_wr_ptr <= wb_next ^ (wb_next >> 1). It is a register output, never decoded combinationally, so it is glitch-free across domains.
- Read pointer sync: rq = gray_rd_ptr after SYNC_STAGES flops. The first stage samples gray_rd_ptr directly.
- Full: wr_full <= (gray(wb_next) == {~rq[ADDR_WIDTH:ADDR_WIDTH-1], rq[ADDR_WIDTH-2:0]}).
- Level: wr_level <= wb_next − gray2bin(rq), modulo 2^(ADDR_WIDTH+1). It is pessimistic, never under-reporting, because rq lags the real read pointer.
- Almost-full: wr_afull <= (level_next ≥ AFULL_LEVEL). level_next is the value being loaded into wr_level.
- Overflow: wr_inc & wr_full sets wr_ovf. wr_clr_ovf clears it. If both occur in the same cycle, set wins. The rejected write changes nothing else.
- Simultaneous write accept and rq advance in the same cycle: both are folded into the next-state values. Full can only stay, assert or deassert consistently with the pair.

## Timing
- Reset values: wb = 0, all sync flops = 0, gray_wr_ptr = 0, wr_full = 0, wr_afull = 0 (AFULL_LEVEL ≥ 1), wr_level = 0, wr_ovf = 0.
- Reset is asynchronous and may hit mid-operation: all state clears immediately with no pending write. The read side must be reset in the same window.
- Write accepted at edge N (wr_en = 1): memory writes wr_addr at N. The new pointer, full, level and afull are visible after N.
- The last free slot written at edge N gives wr_full = 1 after N, so a back-to-back wr_inc at N+1 is blocked.
- Read pointer change on gray_rd_ptr: reflected in full, level and afull SYNC_STAGES+1 W_CLK edges later. That is SYNC_STAGES edges to reach rq, plus the output register.
- No other latency exists. The block accepts one write per cycle at throughput 1.

## Structure
- Shared package fifo_pkg holds the functions bin2gray and gray2bin (width-generic via parameter) and the default SYNC_STAGES constant. The read-side controller uses the same package.
- One sub-module: fifo_gray_sync, a SYNC_STAGES-deep, ADDR_WIDTH+1-bit flop chain with the same reset. The read side reuses it for the write pointer.
- Remaining logic (pointer, flags, overflow) is flat in async_fifo_wr_ctrl.

## Test plan
- Fill, defaults, gray_rd_ptr held at 0:
  - 8 consecutive wr_inc → wr_full = 1 after the 8th edge, with wr_level = 8 and gray_wr_ptr = 4'b1100.
  - wr_afull rises after the 6th edge.
  - wr_en = 0 on the 9th cycle.
- Overflow: full FIFO with wr_inc for 2 cycles → wr_addr and gray_wr_ptr unchanged, wr_ovf = 1. Assert wr_clr_ovf and wr_inc together → wr_ovf stays 1. wr_clr_ovf alone → wr_ovf = 0.
- Drain visibility: full FIFO, gray_rd_ptr stepped 0000→0001→0011 one per cycle → wr_full = 0 exactly 3 edges after the first step, and wr_level settles at 6.
- Wrap-around, reads tracking writes: 40 writes → every gray_wr_ptr transition changes exactly 1 bit, the pointer returns to 0000 after the 16th write, and wr_full never asserts.
- Reset mid-operation: W_RST low for a partial cycle at level 5 → all outputs are 0 immediately, and the first post-reset write goes to wr_addr = 0.
- Parametrised build with ADDR_WIDTH = 5, SYNC_STAGES = 3, AFULL_LEVEL = 30 → full after 32 writes, afull after 30 writes, full deassert latency = 4 edges.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared Gray-code helpers and defaults for the dual-clock FIFO controllers
package fifo_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int GRAY_FN_W           = 32;

  // Callers zero-extend into GRAY_FN_W and cast the result back to their own width.
  function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down, done in log2 doubling steps.
  function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] gray);
    logic [GRAY_FN_W-1:0] bin;
    bin = gray;
    for (int s = 1; s < GRAY_FN_W; s = s * 2) begin
      bin = bin ^ (bin >> s);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray_sync.sv
// rtl/fifo_gray_sync.sv - multi-flop synchroniser for a Gray-coded pointer crossing clock domains
module fifo_gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// rtl/async_fifo_wr_ctrl.sv - write-side pointer, full/almost-full/level flags and overflow for the dual-clock FIFO
module async_fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int AFULL_LEVEL = 6
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  wr_inc,
  input  logic                  wr_clr_ovf,
  input  logic [ADDR_WIDTH:0]   gray_rd_ptr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   gray_wr_ptr,
  output logic                  wr_full,
  output logic                  wr_afull,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_ovf
);

  localparam int               PTR_W     = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] AFULL_THR = PTR_W'(AFULL_LEVEL);

  logic [PTR_W-1:0] wb_q, wb_d;
  logic [PTR_W-1:0] gray_q, gray_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] rq;
  logic [PTR_W-1:0] rq_bin;

  fifo_gray_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk_i  (W_CLK),
    .rst_ni (W_RST),
    .d_i    (gray_rd_ptr),
    .q_o    (rq)
  );

  assign wr_en = wr_inc & ~full_q;

  // Flags are computed from the post-write pointer so a write at edge N is reflected right after N.
  always_comb begin
    wb_d    = wb_q + PTR_W'(wr_en);
    gray_d  = PTR_W'(bin2gray(32'(wb_d)));
    rq_bin  = PTR_W'(gray2bin(32'(rq)));
    full_d  = (gray_d == {~rq[ADDR_WIDTH:ADDR_WIDTH-1], rq[ADDR_WIDTH-2:0]});
    level_d = wb_d - rq_bin;
    afull_d = (level_d >= AFULL_THR);
    ovf_d   = (wr_inc & full_q) | (ovf_q & ~wr_clr_ovf);
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wb_q    <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wb_q    <= wb_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_addr     = wb_q[ADDR_WIDTH-1:0];
  assign gray_wr_ptr = gray_q;
  assign wr_full     = full_q;
  assign wr_afull    = afull_q;
  assign wr_level    = level_q;
  assign wr_ovf      = ovf_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb/tb_async_fifo_wr_ctrl.sv - self-checking bench for the FIFO write-side controller
module tb_async_fifo_wr_ctrl;

  localparam int AW    = 3;
  localparam int SS    = 2;
  localparam int AF    = 6;
  localparam int DEPTH = 8;
  localparam int PMASK = 15;

  logic       W_CLK = 1'b0;
  logic       W_RST = 1'b0;
  logic       wr_inc = 1'b0;
  logic       wr_clr_ovf = 1'b0;
  logic [3:0] gray_rd_ptr = '0;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] gray_wr_ptr;
  logic       wr_full;
  logic       wr_afull;
  logic [3:0] wr_level;
  logic       wr_ovf;

  logic       b_inc = 1'b0;
  logic       b_clr = 1'b0;
  logic [5:0] b_gray_rd = '0;
  logic       b_en;
  logic [4:0] b_addr;
  logic [5:0] b_gray_wr;
  logic       b_full;
  logic       b_afull;
  logic [5:0] b_level;
  logic       b_ovf;

  always #5 W_CLK = ~W_CLK;

  async_fifo_wr_ctrl dut (
    .W_CLK       (W_CLK),
    .W_RST       (W_RST),
    .wr_inc      (wr_inc),
    .wr_clr_ovf  (wr_clr_ovf),
    .gray_rd_ptr (gray_rd_ptr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .gray_wr_ptr (gray_wr_ptr),
    .wr_full     (wr_full),
    .wr_afull    (wr_afull),
    .wr_level    (wr_level),
    .wr_ovf      (wr_ovf)
  );

  async_fifo_wr_ctrl #(
    .ADDR_WIDTH  (5),
    .SYNC_STAGES (3),
    .AFULL_LEVEL (30)
  ) dut_b (
    .W_CLK       (W_CLK),
    .W_RST       (W_RST),
    .wr_inc      (b_inc),
    .wr_clr_ovf  (b_clr),
    .gray_rd_ptr (b_gray_rd),
    .wr_en       (b_en),
    .wr_addr     (b_addr),
    .gray_wr_ptr (b_gray_wr),
    .wr_full     (b_full),
    .wr_afull    (b_afull),
    .wr_level    (b_level),
    .wr_ovf      (b_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: write count and read count (mod 2*DEPTH), and the read
  // count presented at every clock edge since reset.
  int m_wcnt = 0;
  int m_rd   = 0;
  bit m_ovf  = 1'b0;
  int hist[$];

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // The write domain sees the read count that was sampled SS edges ago.
  function automatic int m_rq();
    int idx;
    idx = hist.size() - 1 - SS;
    return (idx < 0) ? 0 : hist[idx];
  endfunction

  function automatic int m_level();
    return (m_wcnt - m_rq()) & PMASK;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wcnt = 0;
    m_rd   = 0;
    m_ovf  = 1'b0;
    hist.delete();
  endtask

  task automatic cycle(input bit inc, input bit clr, input int rd);
    bit en;
    @(negedge W_CLK);
    wr_inc      = inc;
    wr_clr_ovf  = clr;
    m_rd        = rd & PMASK;
    gray_rd_ptr = 4'(gray(m_rd));
    #1;
    en = inc && (m_level() != DEPTH);
    chk("wr_en", 32'(wr_en), 32'(en));
    chk("wr_addr", 32'(wr_addr), 32'(m_wcnt & (DEPTH - 1)));
    @(posedge W_CLK);
    hist.push_back(m_rd);
    m_ovf = (inc && !en) || (m_ovf && !clr);
    if (en) m_wcnt = (m_wcnt + 1) & PMASK;
    #1;
    chk("gray_wr_ptr", 32'(gray_wr_ptr), 32'(gray(m_wcnt)));
    chk("wr_level", 32'(wr_level), 32'(m_level()));
    chk("wr_full", 32'(wr_full), 32'(m_level() == DEPTH));
    chk("wr_afull", 32'(wr_afull), 32'(m_level() >= AF));
    chk("wr_ovf", 32'(wr_ovf), 32'(m_ovf));
  endtask

  initial begin
    logic [3:0] g_hold;
    logic [2:0] a_hold;
    logic [3:0] g_prev;
    int         rd_r;
    int         k;

    // Reset state
    model_reset();
    repeat (2) @(posedge W_CLK);
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_gray", 32'(gray_wr_ptr), 0);
    chk("rst_full", 32'(wr_full), 0);
    chk("rst_afull", 32'(wr_afull), 0);
    chk("rst_level", 32'(wr_level), 0);
    chk("rst_ovf", 32'(wr_ovf), 0);
    @(negedge W_CLK);
    W_RST = 1'b1;

    // Fill with the read pointer parked at 0
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, 0);
      if (i == 5) chk("afull_before_6th", 32'(wr_afull), 0);
      if (i == 6) chk("afull_at_6th", 32'(wr_afull), 1);
      if (i == 7) chk("full_before_8th", 32'(wr_full), 0);
    end
    chk("fill_full", 32'(wr_full), 1);
    chk("fill_level", 32'(wr_level), 8);
    chk("fill_gray", 32'(gray_wr_ptr), 32'h0000_000C);

    // Overflow: two rejected writes, then clear racing a set, then clear alone
    g_hold = gray_wr_ptr;
    a_hold = wr_addr;
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    chk("ovf_addr_hold", 32'(wr_addr), 32'(a_hold));
    chk("ovf_gray_hold", 32'(gray_wr_ptr), 32'(g_hold));
    chk("ovf_set", 32'(wr_ovf), 1);
    cycle(1'b1, 1'b1, 0);
    chk("ovf_set_wins", 32'(wr_ovf), 1);
    cycle(1'b0, 1'b1, 0);
    chk("ovf_cleared", 32'(wr_ovf), 0);

    // Drain visibility: two read steps, full drops on the third edge
    cycle(1'b0, 1'b0, 1);
    chk("drain_full_e1", 32'(wr_full), 1);
    cycle(1'b0, 1'b0, 2);
    chk("drain_full_e2", 32'(wr_full), 1);
    cycle(1'b0, 1'b0, 2);
    chk("drain_full_e3", 32'(wr_full), 0);
    repeat (2) cycle(1'b0, 1'b0, 2);
    chk("drain_level", 32'(wr_level), 6);

    // Bring level to 5, then a partial-cycle reset
    repeat (4) cycle(1'b0, 1'b0, 3);
    chk("pre_rst_level", 32'(wr_level), 5);
    #1;
    W_RST       = 1'b0;
    gray_rd_ptr = '0;
    #1;
    chk("mid_rst_gray", 32'(gray_wr_ptr), 0);
    chk("mid_rst_level", 32'(wr_level), 0);
    chk("mid_rst_addr", 32'(wr_addr), 0);
    chk("mid_rst_afull", 32'(wr_afull), 0);
    chk("mid_rst_full", 32'(wr_full), 0);
    chk("mid_rst_ovf", 32'(wr_ovf), 0);
    #1;
    W_RST = 1'b1;
    model_reset();

    // Wrap-around with reads tracking writes
    g_prev = gray_wr_ptr;
    for (int i = 1; i <= 40; i++) begin
      cycle(1'b1, 1'b0, m_wcnt);
      chk("wrap_one_bit", 32'($countones(gray_wr_ptr ^ g_prev)), 1);
      chk("wrap_no_full", 32'(wr_full), 0);
      if (i == 16) chk("wrap_ptr_zero", 32'(gray_wr_ptr), 0);
      g_prev = gray_wr_ptr;
    end

    // Random traffic; reads never pass the writes actually made
    rd_r = m_rd;
    for (int i = 0; i < 400; i++) begin
      if (((m_wcnt - rd_r) & PMASK) != 0 && $urandom_range(0, 1) == 1)
        rd_r = (rd_r + 1) & PMASK;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rd_r);
    end
    @(negedge W_CLK);
    wr_inc     = 1'b0;
    wr_clr_ovf = 1'b0;

    // Wide build: 32 entries, afull at 30, 3-stage sync
    k = 0;
    while (k < 32) begin
      @(negedge W_CLK);
      b_inc = 1'b1;
      @(posedge W_CLK);
      #1;
      k++;
      if (k == 29) chk("b_afull_29", 32'(b_afull), 0);
      if (k == 30) chk("b_afull_30", 32'(b_afull), 1);
      if (k == 31) chk("b_full_31", 32'(b_full), 0);
    end
    chk("b_full_32", 32'(b_full), 1);
    chk("b_level_32", 32'(b_level), 32);
    @(negedge W_CLK);
    b_inc     = 1'b0;
    b_gray_rd = 6'd1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge W_CLK);
      #1;
      if (e == 3) chk("b_full_e3", 32'(b_full), 1);
      if (e == 4) chk("b_full_e4", 32'(b_full), 0);
    end
    chk("b_level_drain", 32'(b_level), 31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
